// File: rtl/adder_bist_tpg.sv
// Pseudo-random pattern generator for the 32-bit ripple-carry adder BIST.
// A 65-bit Fibonacci LFSR (x^65+x^47+1) drives a, b and c0 under a start/done handshake.
module adder_bist_tpg #(
  parameter int unsigned N_PATTERNS = 1024,
  parameter logic [64:0] SEED       = 65'h0_0000_0000_0000_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        seed_load,
  input  logic [64:0] seed_in,
  input  logic        hold,
  input  logic        abort,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic        c0,
  output logic        pat_valid,
  output logic        busy,
  output logic        done,
  output logic [15:0] pat_count
);

  localparam int unsigned LfsrW = 65;
  localparam int unsigned CntW  = 16;
  localparam logic [CntW-1:0] LastCnt = CntW'(N_PATTERNS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [LfsrW-1:0] lfsr_q;
  logic [LfsrW-1:0] lfsr_d;
  logic [LfsrW-1:0] seed_safe;
  logic [CntW-1:0]  cnt_q;

  assign lfsr_d    = {lfsr_q[LfsrW-2:0], lfsr_q[64] ^ lfsr_q[46]};
  // An all-zero seed would lock the LFSR, so fall back to SEED.
  assign seed_safe = (seed_in == '0) ? SEED : seed_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (seed_load) lfsr_q <= seed_safe;
          if (start) begin
            state_q <= RUN;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          // abort outranks both hold and the terminal-count transition
          if (abort) begin
            state_q <= IDLE;
          end else if (!hold) begin
            lfsr_q <= lfsr_d;
            cnt_q  <= cnt_q + CntW'(1);
            if (cnt_q == LastCnt) state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a         = lfsr_q[64:33];
  assign b         = lfsr_q[32:1];
  assign c0        = lfsr_q[0];
  assign pat_valid = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pat_count = cnt_q;

endmodule

// File: tb/tb_adder_bist_tpg.sv
// Randomized self-checking bench for adder_bist_tpg: two instances (4 and 1024 patterns)
// share stimulus and are compared every cycle against a behavioural model.
module tb_adder_bist_tpg;

  localparam logic [64:0] SEED = 65'h1;
  localparam int          N4   = 4;
  localparam int          ND   = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        seed_load = 1'b0;
  logic [64:0] seed_in = '0;
  logic        hold = 1'b0;
  logic        abort = 1'b0;

  logic [31:0] a4, b4, ad, bd;
  logic        c04, pv4, busy4, done4, c0d, pvd, busyd, doned;
  logic [15:0] cnt4, cntd;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  adder_bist_tpg #(.N_PATTERNS(N4), .SEED(SEED)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .seed_load(seed_load), .seed_in(seed_in),
    .hold(hold), .abort(abort), .a(a4), .b(b4), .c0(c04), .pat_valid(pv4),
    .busy(busy4), .done(done4), .pat_count(cnt4));

  adder_bist_tpg #(.N_PATTERNS(ND), .SEED(SEED)) u_dutd (
    .clk(clk), .rst_n(rst_n), .start(start), .seed_load(seed_load), .seed_in(seed_in),
    .hold(hold), .abort(abort), .a(ad), .b(bd), .c0(c0d), .pat_valid(pvd),
    .busy(busyd), .done(doned), .pat_count(cntd));

  // Behavioural model: mode 0=idle 1=running 2=finished; patterns consumed per run.
  int          m_mode [2] = '{0, 0};
  logic [64:0] m_lfsr [2] = '{SEED, SEED};
  int          m_used [2] = '{0, 0};
  int          m_n    [2] = '{N4, ND};

  function automatic logic [64:0] lfsr_step(input logic [64:0] v);
    logic fb;
    fb = v[64] ^ v[46];
    return (v << 1) | 65'(fb);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_mode[k] = 0; m_lfsr[k] = SEED; m_used[k] = 0;
      end else if (m_mode[k] == 1) begin
        if (abort) m_mode[k] = 0;
        else if (!hold) begin
          m_lfsr[k] = lfsr_step(m_lfsr[k]);
          m_used[k] = m_used[k] + 1;
          if (m_used[k] == m_n[k]) m_mode[k] = 2;
        end
      end else begin
        if (seed_load) m_lfsr[k] = (seed_in == 65'd0) ? SEED : seed_in;
        if (start) begin m_mode[k] = 1; m_used[k] = 0; end
      end
    end
  end

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int k, input logic [31:0] av, input logic [31:0] bv,
                          input logic cv, input logic pv, input logic bz, input logic dn,
                          input logic [15:0] cn);
    logic [64:0] l;
    l = m_lfsr[k];
    chk($sformatf("m%0d_a", k), 65'(av), 65'(l[64:33]));
    chk($sformatf("m%0d_b", k), 65'(bv), 65'(l[32:1]));
    chk($sformatf("m%0d_c0", k), 65'(cv), 65'(l[0]));
    chk($sformatf("m%0d_valid", k), 65'(pv), 65'(m_mode[k] == 1));
    chk($sformatf("m%0d_busy", k), 65'(bz), 65'(m_mode[k] == 1));
    chk($sformatf("m%0d_done", k), 65'(dn), 65'(m_mode[k] == 2));
    chk($sformatf("m%0d_count", k), 65'(cn), 65'(16'(m_used[k])));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      cmp_inst(0, a4, b4, c04, pv4, busy4, done4, cnt4);
      cmp_inst(1, ad, bd, c0d, pvd, busyd, doned, cntd);
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_a"}, 65'(a4), 65'd0);
    chk({tag, "_b"}, 65'(b4), 65'd0);
    chk({tag, "_c0"}, 65'(c04), 65'd1);
    chk({tag, "_flags"}, 65'({pv4, busy4, done4}), 65'd0);
    chk({tag, "_count"}, 65'(cnt4), 65'd0);
    chk({tag, "_dflt_flags"}, 65'({pvd, busyd, doned, c0d}), 65'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_done4();
    int t;
    t = 0;
    while (!done4 && t < 40) begin @(negedge clk); t++; end
    chk("wait_done4", 65'(done4), 65'd1);
  endtask

  int          nvalid;
  logic [31:0] bq[$];
  logic        c0q[$];

  initial begin
    // reset values
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // four-pattern run
    start = 1'b1; @(negedge clk); start = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 6; i++) begin
      if (pv4) begin nvalid++; bq.push_back(b4); c0q.push_back(c04); end
      @(negedge clk);
    end
    chk("run4_valid_cycles", 65'(nvalid), 65'd4);
    if (bq.size() == 4) begin
      chk("run4_b0", 65'(bq[0]), 65'd0);
      chk("run4_c0_0", 65'(c0q[0]), 65'd1);
      chk("run4_b1", 65'(bq[1]), 65'd1);
      chk("run4_c0_1", 65'(c0q[1]), 65'd0);
      chk("run4_b2", 65'(bq[2]), 65'd2);
      chk("run4_b3", 65'(bq[3]), 65'd4);
    end
    chk("run4_done", 65'({done4, busy4}), 65'b10);
    chk("run4_count", 65'(cnt4), 65'd4);
    chk("run4_b_after", 65'(b4), 65'd8);

    // feedback tap on the long run
    do_reset();
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (33) @(negedge clk);
    chk("adv33_a", 65'(ad), 65'd1);
    chk("adv33_bc", 65'({bd, c0d}), 65'd0);
    repeat (14) @(negedge clk);
    chk("adv47_a", 65'(ad), 65'h4000);
    chk("adv47_c0", 65'(c0d), 65'd1);

    // hold while b=1 is presented
    do_reset();
    start = 1'b1; @(negedge clk); start = 1'b0;
    @(negedge clk);
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("hold_b", 65'(b4), 65'd1);
      chk("hold_count", 65'(cnt4), 65'd1);
      chk("hold_valid", 65'(pv4), 65'd1);
      if (i == 3) hold = 1'b0;
      @(negedge clk);
    end
    chk("hold_release_b", 65'(b4), 65'd2);
    wait_done4();
    chk("hold_end_count", 65'(cnt4), 65'd4);

    // seed loading in DONE / lock-up guard
    seed_in = '0; seed_load = 1'b1; @(negedge clk); seed_load = 1'b0;
    chk("seed0_c0", 65'(c04), 65'd1);
    chk("seed0_ab", 65'({a4, b4}), 65'd0);
    seed_in = 65'h1_0000_0000_0000_0000; seed_load = 1'b1; @(negedge clk); seed_load = 1'b0;
    chk("seedmsb_a", 65'(a4), 65'h8000_0000);
    chk("seedmsb_bc", 65'({b4, c04}), 65'd0);

    // abort at pat_count == 2
    start = 1'b1; @(negedge clk); start = 1'b0;
    begin
      int t;
      t = 0;
      while (cnt4 != 16'd2 && t < 20) begin @(negedge clk); t++; end
    end
    chk("abort_reach2", 65'(cnt4), 65'd2);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    chk("abort_flags", 65'({pv4, busy4, done4}), 65'd0);
    chk("abort_count", 65'(cnt4), 65'd2);

    // asynchronous reset mid-run
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset("async_rst");
    @(negedge clk); rst_n = 1'b1;

    // randomized traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      start     = ($urandom % 6) == 0;
      seed_load = ($urandom % 10) == 0;
      seed_in   = (($urandom % 4) == 0) ? 65'd0 : 65'({$urandom, $urandom, $urandom});
      hold      = ($urandom % 4) == 0;
      abort     = ($urandom % 40) == 0;
      rst_n     = ($urandom % 700) != 0;
    end
    @(negedge clk);
    {start, seed_load, hold, abort} = '0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/adder_bist_tpg.md
Name: adder_bist_tpg

Overview:
- Built-in self-test pattern generator that sits directly upstream of the 32-bit ripple-carry adder (adder_noh).
- Drives all 65 adder inputs (a[31:0], b[31:0], c0) from a 65-bit maximal-length Fibonacci LFSR.
- Produces a programmable number of pseudo-random patterns under a start/done handshake, with a hold input so a downstream response compactor can stall it.

Parameters:
- N_PATTERNS, 1024, number of patterns per run; legal range 1..65535.
- SEED, 65'h0_0000_0000_0000_0001, reset and fallback LFSR value; must be nonzero.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a run; sampled in IDLE or DONE only.
- seed_load  input  1  load seed_in into the LFSR; sampled in IDLE or DONE only.
- seed_in  input  65  seed value.
- hold  input  1  downstream stall; freezes the current pattern while in RUN.
- abort  input  1  synchronous return to IDLE from RUN.
- a  output  32  adder operand a, equal to lfsr[64:33].
- b  output  32  adder operand b, equal to lfsr[32:1].
- c0  output  1  adder carry-in, equal to lfsr[0].
- pat_valid  output  1  current a/b/c0 is a live test pattern.
- busy  output  1  high while in RUN.
- done  output  1  run complete; sticky.
- pat_count  output  16  patterns consumed in the current or last run.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, lfsr=SEED, so a=0, b=0, c0=1 with the default SEED.
  - pat_valid=0, busy=0, done=0, pat_count=0.
- LFSR:
  - next = {lfsr[63:0], lfsr[64]^lfsr[46]} (polynomial x^65+x^47+1).
  - a, b and c0 are wired directly from the lfsr register, so there is no combinational path from the inputs to the pattern outputs.
- States: IDLE, RUN, DONE.
  - pat_valid = busy = (state==RUN).
  - done = (state==DONE).
- seed_load in IDLE or DONE: lfsr <= seed_in. If seed_in==0, lfsr <= SEED instead (lock-up guard). Ignored in RUN.
- start in IDLE or DONE:
  - next state RUN, pat_count <= 0, done clears.
  - If seed_load is asserted in the same cycle, the seed is loaded and the first pattern is the loaded seed.
  - start in RUN is ignored.
- RUN, hold=0 (pattern consumed this edge):
  - lfsr <= next, pat_count <= pat_count+1.
  - If pat_count==N_PATTERNS-1: state <= DONE. Exactly N_PATTERNS patterns are presented, the first being the LFSR value at start.
- RUN, hold=1: lfsr, pat_count and state are frozen; pat_valid stays 1. hold is ignored outside RUN.
- abort in RUN: state <= IDLE; lfsr and pat_count keep their current values; done stays 0. abort has priority over hold and over the terminal-count transition.
- DONE: lfsr holds the value after the last advance. A new start continues the sequence from there unless seed_load is applied.
- Latency: the first pattern is valid the cycle after start is sampled. done rises the cycle after the last pattern is consumed.
- Reset mid-run: immediate return to IDLE with reset values, regardless of state.

Test Plan:
- Reset, then check a=0, b=0, c0=1 and pat_valid=busy=done=0, pat_count=0 → all match.
- N_PATTERNS=4, start for 1 cycle, hold=0 → pat_valid high exactly 4 cycles.
  - Patterns presented: (b=0, c0=1), (b=1, c0=0), (b=2), (b=4).
  - Then done=1, busy=0, pat_count=4, b=8.
- Default run from SEED=1 with no hold:
  - After 33 advances: a=1, b=0, c0=0.
  - After 47 advances: lfsr = (1<<47)|1, i.e. a=32'h0000_4000, c0=1, confirming the feedback tap.
- Same setup as the N_PATTERNS=4 case, with hold=1 for 3 cycles while pattern b=1 is presented → b=1 visible for 4 cycles, pat_count stays 1, and the run still ends with pat_count=4.
- seed_load with seed_in=0 in IDLE → lfsr=SEED (c0=1). seed_load with seed_in=65'h1_0000_0000_0000_0000 → a=32'h8000_0000, b=0, c0=0.
- Interrupt checks:
  - abort at pat_count=2 → IDLE, pat_count=2, done=0.
  - Separately, rst_n=0 mid-RUN → outputs return to reset values asynchronously, without waiting for a clock edge.
